// File: rtl/load_ctrl_pkg.sv
// Shared constants and state encoding for the state-memory load sequencer.
package load_ctrl_pkg;

    localparam int unsigned LOAD_DEPTH      = 64;
    localparam int unsigned LOAD_TIMEOUT    = 1000;
    localparam int unsigned LOAD_WORD_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSEMBLE = 3'd1,
        ST_WRITE    = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } load_state_e;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/load_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count flag.
module load_timer #(
    parameter int unsigned W    = 10,
    parameter int unsigned TERM = 999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (ld) begin
            cnt_q <= ld_val;
        end else if (inc) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tc = (cnt_q == W'(TERM));

endmodule

// File: rtl/load_ctrl.sv
// Assembles host bytes into little-endian words and writes them to consecutive
// addresses of the compute state memory; flags completion or inter-byte timeout.
module load_ctrl
    import load_ctrl_pkg::*;
#(
    parameter int unsigned WORD_BYTES = LOAD_WORD_BYTES,
    parameter int unsigned DEPTH      = LOAD_DEPTH,
    parameter int unsigned ADDR_W     = $clog2(LOAD_DEPTH),
    parameter int unsigned TIMEOUT    = LOAD_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start_load,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    rx_ready,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic                    load_done,
    output logic                    busy,
    output logic                    err
);

    localparam int unsigned DATA_W = 8 * WORD_BYTES;
    localparam int unsigned BIDX_W = idx_width(WORD_BYTES);
    localparam int unsigned TMR_W  = idx_width(TIMEOUT);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    load_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [BIDX_W-1:0]   bidx_q, bidx_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                tmr_clr, tmr_inc, tmr_tc;

    load_timer #(
        .W    (TMR_W),
        .TERM (TIMEOUT - 1)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (tmr_inc),
        .tc     (tmr_tc)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            widx_q  <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
        end
    end

    // Next state, datapath updates and handshake strobes; en low freezes everything.
    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        bidx_d   = bidx_q;
        word_d   = word_q;
        tmr_clr  = 1'b0;
        tmr_inc  = 1'b0;
        rx_ready = 1'b0;
        wr_en    = 1'b0;

        if (en) begin
            rx_ready = (state_q == ST_ASSEMBLE) && !start_load;
            wr_en    = (state_q == ST_WRITE);

            if (start_load) begin
                state_d = ST_ASSEMBLE;
                widx_d  = '0;
                bidx_d  = '0;
                tmr_clr = 1'b1;
            end else begin
                case (state_q)
                    ST_ASSEMBLE: begin
                        if (rx_valid) begin
                            for (int unsigned k = 0; k < WORD_BYTES; k++) begin
                                if (bidx_q == BIDX_W'(k)) begin
                                    word_d[8*k +: 8] = rx_data;
                                end
                            end
                            tmr_clr = 1'b1;
                            if (bidx_q == LAST_BYTE) begin
                                state_d = ST_WRITE;
                            end else begin
                                bidx_d = bidx_q + BIDX_W'(1);
                            end
                        end else if (tmr_tc) begin
                            state_d = ST_ERR;
                        end else begin
                            tmr_inc = 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        if (widx_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            widx_d  = widx_q + ADDR_W'(1);
                            bidx_d  = '0;
                            state_d = ST_ASSEMBLE;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    assign wr_addr   = widx_q;
    assign wr_data   = word_q;
    assign load_done = (state_q == ST_DONE);
    assign busy      = (state_q == ST_ASSEMBLE) || (state_q == ST_WRITE);
    assign err       = (state_q == ST_ERR);

endmodule

// File: tb/tb_load_ctrl.sv
// Directed bench for load_ctrl: full load, timeout, restart, enable gating, async reset.
module tb_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start_load;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        load_done;
    logic        busy;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    logic [15:0] mem [0:63];
    int          wr_total = 0;
    logic [5:0]  last_addr = '0;
    int          wr_base;

    always #5 clk = ~clk;

    load_ctrl #(
        .WORD_BYTES (2),
        .DEPTH      (64),
        .ADDR_W     (6),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start_load (start_load),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .load_done  (load_done),
        .busy       (busy),
        .err        (err)
    );

    // Write-port model of the state memory.
    always @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
            last_addr    <= wr_addr;
            wr_total     <= wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'h0);
        chk({tag, "_wr_en"},    32'(wr_en),    32'h0);
        chk({tag, "_wr_addr"},  32'(wr_addr),  32'h0);
        chk({tag, "_wr_data"},  32'(wr_data),  32'h0);
        chk({tag, "_done"},     32'(load_done), 32'h0);
        chk({tag, "_busy"},     32'(busy),     32'h0);
        chk({tag, "_err"},      32'(err),      32'h0);
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
    endtask

    // Offer one byte and return at the negedge after it has been accepted.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        while (!rx_ready && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("rx_ready_wait", 32'(rx_ready), 32'h1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic full_load(input string tag);
        wr_base = wr_total;
        pulse_start();
        chk({tag, "_busy_start"}, 32'(busy), 32'h1);
        chk({tag, "_done_clr"},   32'(load_done), 32'h0);
        for (int b = 0; b < 128; b++) begin
            send_byte(8'(b));
        end
        chk({tag, "_last_wr_en"},   32'(wr_en),   32'h1);
        chk({tag, "_last_wr_addr"}, 32'(wr_addr), 32'd63);
        chk({tag, "_last_wr_data"}, 32'(wr_data), 32'h7F7E);
        chk({tag, "_done_low"},     32'(load_done), 32'h0);
        @(negedge clk);
        chk({tag, "_done"},      32'(load_done), 32'h1);
        chk({tag, "_busy_end"},  32'(busy),      32'h0);
        chk({tag, "_wr_en_end"}, 32'(wr_en),     32'h0);
        chk({tag, "_writes"},    32'(wr_total - wr_base), 32'd64);
        chk({tag, "_mem0"},      32'(mem[0]),  32'h0100);
        chk({tag, "_mem10"},     32'(mem[10]), 32'h1514);
        chk({tag, "_mem63"},     32'(mem[63]), 32'h7F7E);
        rx_valid = 1'b1;
        #1;
        chk({tag, "_rdy_done"}, 32'(rx_ready), 32'h0);
        @(negedge clk);
        rx_valid = 1'b0;
        chk({tag, "_done_hold"}, 32'(load_done), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        en         = 1'b1;
        start_load = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);

        // Full load of 128 bytes 0x00..0x7F.
        full_load("full1");

        // Stall after three bytes: one write, then timeout after 16 idle cycles.
        wr_base = wr_total;
        pulse_start();
        chk("stall_done_clr", 32'(load_done), 32'h0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (15) @(negedge clk);
        chk("stall_err_15", 32'(err), 32'h0);
        @(negedge clk);
        chk("stall_err_16",  32'(err),       32'h1);
        chk("stall_done",    32'(load_done), 32'h0);
        chk("stall_busy",    32'(busy),      32'h0);
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        #1;
        chk("stall_rdy", 32'(rx_ready), 32'h0);
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        chk("stall_err_hold", 32'(err), 32'h1);
        chk("stall_writes",   32'(wr_total - wr_base), 32'd1);
        chk("stall_addr",     32'(last_addr), 32'd0);

        // Restart after ten words with a coincident byte that must be dropped.
        wr_base = wr_total;
        pulse_start();
        chk("rst_err_clr", 32'(err), 32'h0);
        for (int b = 0; b < 20; b++) begin
            send_byte(8'(8'h40 + b));
        end
        @(negedge clk);
        chk("restart_writes10", 32'(wr_total - wr_base), 32'd10);
        chk("restart_addr10",   32'(wr_addr), 32'd10);
        start_load = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'hAA;
        #1;
        chk("restart_rdy", 32'(rx_ready), 32'h0);
        @(negedge clk);
        start_load = 1'b0;
        rx_valid   = 1'b0;
        chk("restart_addr0", 32'(wr_addr),   32'd0);
        chk("restart_busy",  32'(busy),      32'h1);
        chk("restart_err",   32'(err),       32'h0);
        chk("restart_done",  32'(load_done), 32'h0);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("restart_wr_en",   32'(wr_en),   32'h1);
        chk("restart_wr_addr", 32'(wr_addr), 32'd0);
        chk("restart_wr_data", 32'(wr_data), 32'h2211);

        // Enable gating mid-word: timeout and partial word frozen while en is low.
        pulse_start();
        wr_base = wr_total;
        send_byte(8'h5A);
        repeat (10) @(negedge clk);
        en       = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        #1;
        chk("en_rdy_low", 32'(rx_ready), 32'h0);
        repeat (50) @(negedge clk);
        chk("en_err",    32'(err),   32'h0);
        chk("en_busy",   32'(busy),  32'h1);
        chk("en_wr_en",  32'(wr_en), 32'h0);
        chk("en_writes", 32'(wr_total - wr_base), 32'd0);
        en       = 1'b1;
        rx_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("en_err_15", 32'(err), 32'h0);
        send_byte(8'hA5);
        chk("en_wr_en_word",  32'(wr_en),   32'h1);
        chk("en_wr_addr",     32'(wr_addr), 32'd0);
        chk("en_wr_data",     32'(wr_data), 32'hA55A);

        // Asynchronous reset during a WRITE cycle at a non-zero address.
        @(negedge clk);
        pulse_start();
        for (int b = 0; b < 6; b++) begin
            send_byte(8'(8'hC0 + b));
        end
        chk("arst_pre_wr_en",   32'(wr_en),   32'h1);
        chk("arst_pre_wr_addr", 32'(wr_addr), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk_outputs_zero("arst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_idle_busy", 32'(busy), 32'h0);
        full_load("full2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
